// File: rtl/alu_writeback.sv
// Execute/writeback stage: ALU ops and a shift-add multiply feeding the register file write port.
// Latency: single-cycle ops write back at the accept edge; MUL writes back 16 edges after accept.
// Backpressure: in_ready is high only in IDLE; in_valid while busy is ignored, not queued.
module alu_writeback #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic [ADDR_W-1:0] dest_addr,
  output logic [WIDTH-1:0]  C,
  output logic [ADDR_W-1:0] Caddr,
  output logic              load,
  output logic              carry,
  output logic              zero
);

  // Shift amount and multiply bit counter both span log2(WIDTH) bits.
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [WIDTH-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic [WIDTH-1:0]    c_q, c_d;
  logic [ADDR_W-1:0]   caddr_q, caddr_d;
  logic                load_q, load_d;
  logic                carry_q, carry_d;
  logic                zero_q, zero_d;

  logic [WIDTH:0]      sum_w;
  logic [WIDTH:0]      diff_w;
  logic [CNT_W-1:0]    shamt;
  logic [WIDTH-1:0]    alu_res;
  logic                alu_carry;
  logic [WIDTH-1:0]    acc_step;
  logic                accept;

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid & in_ready;
  assign shamt    = B[CNT_W-1:0];

  // Single-cycle ALU result; the extra top bit of sum/diff yields carry and borrow.
  always_comb begin
    sum_w     = {1'b0, A} + {1'b0, B};
    diff_w    = {1'b0, A} - {1'b0, B};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res   = sum_w[WIDTH-1:0];
        alu_carry = sum_w[WIDTH];
      end
      OP_SUB: begin
        alu_res   = diff_w[WIDTH-1:0];
        alu_carry = ~diff_w[WIDTH];
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_SHL:  alu_res = A << shamt;
      OP_SHR:  alu_res = A >> shamt;
      default: alu_res = '0;
    endcase
  end

  // One multiply step: add the shifted multiplicand when the current multiplier LSB is set.
  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Next-state and writeback control; outputs hold unless a write is issued.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    dest_d   = dest_q;
    c_d      = c_q;
    caddr_d  = caddr_q;
    load_d   = 1'b0;
    carry_d  = carry_q;
    zero_d   = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            mcand_d  = A;
            mplier_d = B;
            dest_d   = dest_addr;
            acc_d    = '0;
            count_d  = '0;
            state_d  = ST_MUL;
          end else begin
            c_d     = alu_res;
            caddr_d = dest_addr;
            carry_d = alu_carry;
            zero_d  = (alu_res == '0);
            load_d  = 1'b1;
          end
        end
      end
      ST_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == CNT_W'(WIDTH - 1)) begin
          c_d     = acc_step;
          caddr_d = dest_q;
          carry_d = 1'b0;
          zero_d  = (acc_step == '0);
          load_d  = 1'b1;
          count_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any multiply in flight.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      dest_q   <= '0;
      c_q      <= '0;
      caddr_q  <= '0;
      load_q   <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      dest_q   <= dest_d;
      c_q      <= c_d;
      caddr_q  <= caddr_d;
      load_q   <= load_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  assign C     = c_q;
  assign Caddr = caddr_q;
  assign load  = load_q;
  assign carry = carry_q;
  assign zero  = zero_q;

endmodule
